serv_ibus_narrow: RTL and testbench

- Instruction-fetch bridge directly downstream of the core's PC/fetch control.
- Consumes the core's 32-bit instruction request: word address plus cyc, held until ack.
- Reads each 32-bit instruction from a narrower memory (8 or 16 bits) as a sequence of beats, assembles the word little-endian, and returns it with a single-cycle ack.
- Lets SERV run from byte-wide SPI/parallel flash or SRAM with no core changes.

---
 rtl/serv_ibus_narrow.sv | 110 +++++++++++
 tb/tb_serv_ibus_narrow.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serv_ibus_narrow.sv
// serv_ibus_narrow
// Instruction-fetch bridge between SERV's 32-bit instruction bus and a narrower
// (8/16-bit) or same-width (32-bit) memory. Each fetch is split into BEATS memory
// beats. The beats are assembled little-endian into one 32-bit word, which is
// returned to the core with a single-cycle ack.
//
// Ports:
//   clk         clock
//   i_rst       synchronous active-high reset
//   i_ibus_adr  core fetch address (bits [1:0] ignored)
//   i_ibus_cyc  core fetch request, held high until o_ibus_ack
//   o_ibus_rdt  assembled instruction word, valid while o_ibus_ack is high
//   o_ibus_ack  one-cycle completion pulse
//   o_mem_adr   byte address of the current beat
//   o_mem_req   beat request, held until i_mem_ack
//   i_mem_ack   beat complete, i_mem_rdt valid
//   i_mem_rdt   beat data
module serv_ibus_narrow #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [31:0]      i_ibus_adr,
  input  logic             i_ibus_cyc,
  output logic [31:0]      o_ibus_rdt,
  output logic             o_ibus_ack,
  output logic [31:0]      o_mem_adr,
  output logic             o_mem_req,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdt
);

  localparam int unsigned BEATS = 32 / WIDTH;
  localparam logic [1:0]  LastBeat = 2'(BEATS - 1);
  localparam logic [31:0] AdrStep = 32'(WIDTH / 8);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StAck   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_rdt;
  logic [31:0] r_mem_adr;
  logic        r_mem_req;

  // Word alignment is implied; the low address bits carry no information here.
  logic w_unused_adr_lsb;
  assign w_unused_adr_lsb = ^i_ibus_adr[1:0];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= 2'd0;
      r_rdt     <= 32'd0;
      r_mem_adr <= 32'd0;
      r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_ibus_cyc) begin
            r_mem_adr <= {i_ibus_adr[31:2], 2'b00};
            r_cnt     <= 2'd0;
            r_mem_req <= 1'b1;
            r_state   <= StFetch;
          end
        end
        StFetch: begin
          if (!i_ibus_cyc) begin
            // Abort: a beat still in flight must finish its handshake first.
            if (i_mem_ack) begin
              r_mem_req <= 1'b0;
              r_state   <= StIdle;
            end else begin
              r_state <= StDrain;
            end
          end else if (i_mem_ack) begin
            for (int b = 0; b < int'(BEATS); b++) begin
              if (r_cnt == 2'(b)) r_rdt[b*WIDTH +: WIDTH] <= i_mem_rdt;
            end
            if (r_cnt == LastBeat) begin
              r_mem_req <= 1'b0;
              r_state   <= StAck;
            end else begin
              r_cnt     <= r_cnt + 2'd1;
              r_mem_adr <= r_mem_adr + AdrStep;
            end
          end
        end
        // The core drops cyc on the edge where it sees ack, so IDLE must not
        // look at cyc in this cycle.
        StAck: r_state <= StIdle;
        StDrain: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ibus_rdt = r_rdt;
  assign o_ibus_ack = (r_state == StAck);
  assign o_mem_adr  = r_mem_adr;
  assign o_mem_req  = r_mem_req;

endmodule

// File: tb/tb_serv_ibus_narrow.sv
// tb_serv_ibus_narrow
// Bench for serv_ibus_narrow (WIDTH=8). The driver issues fetches and pushes the
// expected word into a queue. A monitor pops the queue on every o_ibus_ack.
// The memory model supplies data as a function of the byte address and inserts a
// configurable number of wait states per beat.
module tb_serv_ibus_narrow;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned BEATS = 32 / WIDTH;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [31:0]      i_ibus_adr = 32'd0;
  logic             i_ibus_cyc = 1'b0;
  logic [31:0]      o_ibus_rdt;
  logic             o_ibus_ack;
  logic [31:0]      o_mem_adr;
  logic             o_mem_req;
  logic             i_mem_ack = 1'b0;
  logic [WIDTH-1:0] i_mem_rdt = '0;

  serv_ibus_narrow #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .o_mem_adr  (o_mem_adr),
    .o_mem_req  (o_mem_req),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdt  (i_mem_rdt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  int          waits = 0;
  logic [7:0]  salt  = 8'd0;
  logic        rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= i_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: each byte is its own address low byte, XORed with a salt.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ salt;
  endfunction

  // Reference: the aligned word, byte 0 lowest, address wraps modulo 2^32.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'h3;
    return {mem_byte(base + 32'd3), mem_byte(base + 32'd2),
            mem_byte(base + 32'd1), mem_byte(base)};
  endfunction

  // Memory model with `waits` idle cycles before each beat's ack.
  int          wcnt = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_adr = 32'd0;

  always @(negedge clk) begin
    if (prev_pend && !rst_seen) begin
      check("req_hold", 32'(o_mem_req), 32'd1);
      check("adr_hold", o_mem_adr, prev_adr);
    end
    prev_pend = 1'b0;
    if (o_mem_req) begin
      if (wcnt >= waits) begin
        i_mem_ack = 1'b1;
        for (int k = 0; k < int'(WIDTH / 8); k++)
          i_mem_rdt[k*8 +: 8] = mem_byte(o_mem_adr + 32'(k));
        wcnt = 0;
      end else begin
        i_mem_ack = 1'b0;
        i_mem_rdt = WIDTH'($urandom);
        wcnt++;
        prev_pend = 1'b1;
        prev_adr  = o_mem_adr;
      end
    end else begin
      i_mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Scoreboard monitor.
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    if (prev_ack) begin
      check("ack_single_pulse", 32'(o_ibus_ack), 32'd0);
      check("no_req_after_ack", 32'(o_mem_req), 32'd0);
    end
    prev_ack = o_ibus_ack;
    if (o_ibus_ack) begin
      check("no_req_in_ack", 32'(o_mem_req), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack with rdt %08h, expected no ack", o_ibus_rdt);
      end else begin
        check("rdt", o_ibus_rdt, exp_q.pop_front());
      end
    end
  end

  // abort_at=0: run to completion; otherwise drop cyc at that cycle of the fetch.
  task automatic fetch(input logic [31:0] a, input int w, input logic [7:0] s,
                       input int abort_at);
    int k;
    int n;
    bit done;
    @(negedge clk);
    waits      = w;
    salt       = s;
    i_ibus_adr = a;
    i_ibus_cyc = 1'b1;
    if (abort_at == 0) exp_q.push_back(ref_word(a));
    k    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      if (o_ibus_ack) begin
        i_ibus_cyc = 1'b0;
        done = 1'b1;
        if (abort_at == 0) check("latency", 32'(k), 32'(1 + BEATS * (w + 1)));
      end else if (k == abort_at) begin
        i_ibus_cyc = 1'b0;
        n = 0;
        while (o_mem_req && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("drain_release", 32'(o_mem_req), 32'd0);
        done = 1'b1;
      end else if (k > 400) begin
        total++;
        bad++;
        $display("FAIL fetch_timeout: got no ack after %0d cycles, expected ack", k);
        i_ibus_cyc = 1'b0;
        done = 1'b1;
      end else begin
        // Address must be ignored while busy.
        i_ibus_adr = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ab;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(o_ibus_ack), 32'd0);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_rdt", o_ibus_rdt, 32'd0);
    check("rst_adr", o_mem_adr, 32'd0);
    i_rst = 1'b0;

    fetch(32'h0000_0100, 0, 8'h00, 0);  // expects 0x03020100
    fetch(32'h0000_0008, 2, 8'h00, 0);
    fetch(32'h0000_0206, 1, 8'h5a, 0);
    fetch(32'hFFFF_FFFC, 0, 8'h33, 0);
    fetch(32'h0000_0020, 3, 8'h00, 10); // abort while beat 2 pending
    fetch(32'h0000_0010, 0, 8'h00, 0);
    fetch(32'h0000_0030, 0, 8'h11, 4);  // abort on final beat's ack

    // Reset during beat 1 of 4.
    @(negedge clk);
    waits = 0;
    salt = 8'h00;
    i_ibus_adr = 32'h40;
    i_ibus_cyc = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check("midrst_req", 32'(o_mem_req), 32'd0);
    check("midrst_ack", 32'(o_ibus_ack), 32'd0);
    check("midrst_rdt", o_ibus_rdt, 32'd0);
    check("midrst_adr", o_mem_adr, 32'd0);
    i_rst = 1'b0;
    i_ibus_cyc = 1'b0;
    fetch(32'h0000_0008, 0, 8'h00, 0);

    // Back-to-back fetches.
    fetch(32'h0000_0000, 0, 8'h77, 0);
    fetch(32'h0000_0004, 0, 8'h77, 0);

    for (int i = 0; i < 40; i++) begin
      w  = int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BEATS * (w + 1))) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      fetch($urandom, w, 8'($urandom), ab);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
